// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type, iteration count and a magnitude helper.
package muldiv_pkg;

    localparam int MD_XLEN = 32;
    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    // |v| for signed ops; 0x80000000 stays 0x80000000, read as unsigned.
    function automatic logic [MD_XLEN-1:0] md_abs(input logic [MD_XLEN-1:0] v,
                                                   input logic              is_signed);
        if (is_signed && v[MD_XLEN-1]) begin
            md_abs = ~v + {{(MD_XLEN-1){1'b0}}, 1'b1};
        end else begin
            md_abs = v;
        end
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath on the 64-bit accumulator:
// LSB-first shift-add for multiply, MSB-first restoring subtract for divide.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   operand,
    input  logic              bit_in,
    output logic [2*XLEN-1:0] acc_out
);

    logic [XLEN:0] sum_s;
    logic [XLEN:0] rem_sh_s;
    logic [XLEN:0] diff_s;

    // Divide keeps {remainder, quotient}; multiply keeps the partial product shifting right.
    always_comb begin
        sum_s    = {1'b0, acc_in[2*XLEN-1:XLEN]} + {1'b0, operand};
        rem_sh_s = {acc_in[2*XLEN-1:XLEN], bit_in};
        diff_s   = rem_sh_s - {1'b0, operand};
        if (is_div) begin
            if (diff_s[XLEN]) begin
                acc_out = {rem_sh_s[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
            end else begin
                acc_out = {diff_s[XLEN-1:0], acc_in[XLEN-2:0], 1'b1};
            end
        end else begin
            if (bit_in) begin
                acc_out = {sum_s, acc_in[XLEN-1:1]};
            end else begin
                acc_out = {1'b0, acc_in[2*XLEN-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit mult/multu/div/divu unit owning the HI/LO registers;
// busy stalls the pipeline while an operation runs.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN,
    parameter int ITER = MD_ITER
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            wr_hi,
    input  logic            wr_lo,
    input  logic [XLEN-1:0] wdata,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic            div_by_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int              CNT_W    = $clog2(ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [XLEN-1:0]   ONE_X    = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] ONE_2X   = {{(2*XLEN-1){1'b0}}, 1'b1};

    md_state_e         state_r;
    md_state_e         next_state_s;
    logic              busy_r;
    logic              done_r;
    logic              dbz_r;
    logic [XLEN-1:0]   hi_r;
    logic [XLEN-1:0]   lo_r;
    logic [XLEN-1:0]   a_mag_r;
    logic [XLEN-1:0]   b_mag_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [2*XLEN-1:0] acc_r;
    logic              is_div_r;
    logic              neg_res_r;
    logic              neg_rem_r;

    logic              signed_op_s;
    logic              div_op_s;
    logic              b_zero_s;
    logic              load_s;
    logic              dz_s;
    logic              hi_we_s;
    logic              lo_we_s;
    logic              step_s;
    logic              finish_s;
    logic [XLEN-1:0]   step_operand_s;
    logic              step_bit_s;
    logic [2*XLEN-1:0] acc_next_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   res_hi_s;
    logic [XLEN-1:0]   res_lo_s;

    assign signed_op_s    = (op == MD_MULT) || (op == MD_DIV);
    assign div_op_s       = (op == MD_DIV)  || (op == MD_DIVU);
    assign b_zero_s       = (b == {XLEN{1'b0}});
    assign step_operand_s = is_div_r ? b_mag_r : a_mag_r;
    // Divide consumes dividend bits MSB first, multiply consumes multiplier bits LSB first.
    assign step_bit_s     = is_div_r ? a_mag_r[CNT_LAST - cnt_r] : b_mag_r[cnt_r];

    muldiv_step #(
        .XLEN(XLEN)
    ) u_step (
        .is_div (is_div_r),
        .acc_in (acc_r),
        .operand(step_operand_s),
        .bit_in (step_bit_s),
        .acc_out(acc_next_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= MD_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; flush and completion both drop back to IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            MD_IDLE: begin
                if (load_s) begin
                    next_state_s = MD_RUN;
                end else begin
                    next_state_s = MD_IDLE;
                end
            end
            MD_RUN: begin
                if (flush || finish_s) begin
                    next_state_s = MD_IDLE;
                end else begin
                    next_state_s = MD_RUN;
                end
            end
            default: next_state_s = MD_IDLE;
        endcase
    end

    // FSM action decode; an mthi/mtlo in the same cycle drops the start.
    always_comb begin
        load_s   = 1'b0;
        dz_s     = 1'b0;
        hi_we_s  = 1'b0;
        lo_we_s  = 1'b0;
        step_s   = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            MD_IDLE: begin
                hi_we_s = wr_hi;
                lo_we_s = wr_lo;
                if (start && !wr_hi && !wr_lo) begin
                    if (div_op_s && b_zero_s) begin
                        dz_s = 1'b1;
                    end else begin
                        load_s = 1'b1;
                    end
                end else begin
                    load_s = 1'b0;
                end
            end
            MD_RUN: begin
                if (flush) begin
                    step_s = 1'b0;
                end else begin
                    step_s   = 1'b1;
                    finish_s = (cnt_r == CNT_LAST);
                end
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // Sign fix applied to the final accumulator value as it is written back.
    always_comb begin
        prod_s = neg_res_r ? (~acc_next_s + ONE_2X) : acc_next_s;
        if (is_div_r) begin
            res_lo_s = neg_res_r ? (~acc_next_s[XLEN-1:0] + ONE_X) : acc_next_s[XLEN-1:0];
            res_hi_s = neg_rem_r ? (~acc_next_s[2*XLEN-1:XLEN] + ONE_X)
                                 : acc_next_s[2*XLEN-1:XLEN];
        end else begin
            res_lo_s = prod_s[XLEN-1:0];
            res_hi_s = prod_s[2*XLEN-1:XLEN];
        end
    end

    // Status outputs; done and div_by_zero only ever last one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
        end else begin
            busy_r <= (next_state_s == MD_RUN);
            done_r <= finish_s || dz_s;
            dbz_r  <= dz_s;
        end
    end

    // Operand magnitudes, sign flags, accumulator and iteration counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_mag_r   <= {XLEN{1'b0}};
            b_mag_r   <= {XLEN{1'b0}};
            acc_r     <= {(2*XLEN){1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            is_div_r  <= 1'b0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
        end else if (load_s) begin
            a_mag_r   <= md_abs(a, signed_op_s);
            b_mag_r   <= md_abs(b, signed_op_s);
            acc_r     <= {(2*XLEN){1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            is_div_r  <= div_op_s;
            neg_res_r <= signed_op_s && (a[XLEN-1] ^ b[XLEN-1]);
            neg_rem_r <= signed_op_s && a[XLEN-1];
        end else if (step_s) begin
            acc_r <= acc_next_s;
            if (!finish_s) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            acc_r <= acc_r;
        end
    end

    // HI/LO: completion write-back, otherwise mthi/mtlo while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_r <= {XLEN{1'b0}};
            lo_r <= {XLEN{1'b0}};
        end else if (finish_s) begin
            hi_r <= res_hi_s;
            lo_r <= res_lo_s;
        end else begin
            if (hi_we_s) begin
                hi_r <= wdata;
            end else begin
                hi_r <= hi_r;
            end
            if (lo_we_s) begin
                lo_r <= wdata;
            end else begin
                lo_r <= lo_r;
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_r;
    assign hi          = hi_r;
    assign lo          = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model compared
// every cycle, plus directed vectors with hand-computed results.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdata;
    logic        flush;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .wr_hi      (wr_hi),
        .wr_lo      (wr_lo),
        .wdata      (wdata),
        .flush      (flush),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .hi         (hi),
        .lo         (lo)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference result {hi, lo} from plain arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] f_op,
                                               input logic [31:0] fa,
                                               input logic [31:0] fb);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] res;
        sa = longint'($signed(fa));
        sb = longint'($signed(fb));
        case (f_op)
            2'b00: res = sa * sb;
            2'b01: res = {32'd0, fa} * {32'd0, fb};
            2'b10: begin
                q   = sa / sb;
                r   = sa % sb;
                res = {r[31:0], q[31:0]};
            end
            default: res = {fa % fb, fa / fb};
        endcase
        return res;
    endfunction

    // Transaction-level model: an op occupies 32 cycles, then HI/LO update.
    logic        m_busy;
    int          m_left;
    logic        m_done;
    logic        m_dbz;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [63:0] m_pend;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_left <= 0;
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
            m_pend <= 64'd0;
        end else begin
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            if (m_busy) begin
                if (flush) begin
                    m_busy <= 1'b0;
                end else if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_hi   <= m_pend[63:32];
                    m_lo   <= m_pend[31:0];
                    m_done <= 1'b1;
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (wr_hi || wr_lo) begin
                if (wr_hi) m_hi <= wdata;
                if (wr_lo) m_lo <= wdata;
            end else if (start) begin
                if (op[1] && b == 32'd0) begin
                    m_done <= 1'b1;
                    m_dbz  <= 1'b1;
                end else begin
                    m_busy <= 1'b1;
                    m_left <= 32;
                    m_pend <= ref_result(op, a, b);
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("busy", {31'd0, busy}, {31'd0, m_busy});
            check("done", {31'd0, done}, {31'd0, m_done});
            check("div_by_zero", {31'd0, div_by_zero}, {31'd0, m_dbz});
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output bit seen, output int busy_cyc, output int waited);
        seen     = 1'b0;
        busy_cyc = 0;
        waited   = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            waited++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cyc++;
        end
    endtask

    task automatic run_op(input logic [1:0] t_op, input logic [31:0] ta, input logic [31:0] tb_,
                          output bit seen, output int busy_cyc, output int waited);
        tick();
        start = 1'b1;
        op    = t_op;
        a     = ta;
        b     = tb_;
        tick();
        start = 1'b0;
        wait_done(seen, busy_cyc, waited);
    endtask

    task automatic mt(input bit to_hi, input logic [31:0] data);
        tick();
        wr_hi = to_hi;
        wr_lo = !to_hi;
        wdata = data;
        tick();
        wr_hi = 1'b0;
        wr_lo = 1'b0;
    endtask

    initial begin
        bit seen;
        int bc;
        int wc;
        rst = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
        wr_hi = 1'b0; wr_lo = 1'b0; wdata = 32'd0; flush = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, seen, bc, wc);
        check("mult_done_seen", {31'd0, seen}, 32'd1);
        check("mult_busy_cycles", bc, 32'd32);
        check("mult_latency", wc, 32'd33);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFE);
        check("mult_dbz", {31'd0, div_by_zero}, 32'd0);

        run_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, seen, bc, wc);
        check("multu_done_seen", {31'd0, seen}, 32'd1);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, seen, bc, wc);
        check("div_done_seen", {31'd0, seen}, 32'd1);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        run_op(2'b11, 32'd100, 32'd7, seen, bc, wc);
        check("divu_done_seen", {31'd0, seen}, 32'd1);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        mt(1'b1, 32'h11);
        mt(1'b0, 32'h22);
        run_op(2'b10, 32'd5, 32'd0, seen, bc, wc);
        check("dz_done_seen", {31'd0, seen}, 32'd1);
        check("dz_latency", wc, 32'd1);
        check("dz_busy_cycles", bc, 32'd0);
        check("dz_flag", {31'd0, div_by_zero}, 32'd1);
        check("dz_hi", hi, 32'h11);
        check("dz_lo", lo, 32'h22);

        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, seen, bc, wc);
        check("ovf_done_seen", {31'd0, seen}, 32'd1);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'h0000_0000);

        // mthi together with start: write wins, start dropped.
        tick();
        wr_hi = 1'b1; wdata = 32'hAB; start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3;
        tick();
        wr_hi = 1'b0; start = 1'b0;
        @(negedge clk);
        check("wrstart_busy", {31'd0, busy}, 32'd0);
        check("wrstart_hi", hi, 32'hAB);

        // Second start and an mtlo while busy are both ignored.
        tick();
        start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
        wr_lo = 1'b1; wdata = 32'hDEAD;
        tick();
        start = 1'b0; wr_lo = 1'b0;
        wait_done(seen, bc, wc);
        check("restart_done_seen", {31'd0, seen}, 32'd1);
        check("restart_lo", lo, 32'd15);
        check("restart_hi", hi, 32'd0);

        // Flush mid-operation: no done, HI/LO untouched.
        tick();
        start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd7;
        tick();
        start = 1'b0;
        repeat (3) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_done", {31'd0, done}, 32'd0);
        wait_done(seen, bc, wc);
        check("flush_no_done", {31'd0, seen}, 32'd0);
        check("flush_lo", lo, 32'd15);
        check("flush_hi", hi, 32'd0);

        // Asynchronous reset mid-operation.
        mt(1'b1, 32'h55);
        tick();
        start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd6;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        tick();
        rst = 1'b0;

        run_op(2'b11, 32'd100, 32'd7, seen, bc, wc);
        check("post_rst_done_seen", {31'd0, seen}, 32'd1);
        check("post_rst_lo", lo, 32'd14);
        check("post_rst_hi", hi, 32'd2);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
